// File: rtl/fft_bf_sequencer.sv
// Radix-2 DIF butterfly sequencer for an in-place N-point FFT.
// Walks every stage and butterfly and issues operand and twiddle read addresses.
// The butterfly enable and the write-back addresses come out of a two-deep delay
// pipeline, so they line up with 1-cycle RAM/ROM reads and a 1-cycle butterfly.
module fft_bf_sequencer #(
    parameter int unsigned LOG2N = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             bf_enable,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic [3:0]       stage
);

    localparam int unsigned N    = 1 << LOG2N;
    localparam int unsigned HALF = N / 2;
    localparam int unsigned KW   = LOG2N - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [KW-1:0]    k;
    logic             drain_cnt;
    logic [3:0]       stage_q;
    logic             last_k;
    logic             last_stage;

    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] mask;
    logic [LOG2N-1:0] kx;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-1:0] tw_full;

    logic [LOG2N-1:0] addr_a_d1;
    logic [LOG2N-1:0] addr_b_d1;

    assign last_k     = (k == KW'(HALF - 1));
    assign last_stage = (stage_q == 4'(LOG2N - 1));
    assign stage      = stage_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and status/read-strobe outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (last_k) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt) begin
                    state_next = last_stage ? DONE : RUN;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Butterfly, drain and stage counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            k         <= '0;
            drain_cnt <= 1'b0;
            stage_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k         <= '0;
                        drain_cnt <= 1'b0;
                        stage_q   <= '0;
                    end
                end
                RUN: begin
                    if (last_k) begin
                        k <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                    drain_cnt <= 1'b0;
                end
                DRAIN: begin
                    drain_cnt <= ~drain_cnt;
                    if (drain_cnt && !last_stage) begin
                        stage_q <= stage_q + 4'd1;
                    end
                end
                DONE: begin
                    stage_q <= '0;
                end
                default: begin
                    k <= '0;
                end
            endcase
        end
    end

    // Address generation: a is k with a zero bit inserted at the span position,
    // b sets that bit, and the twiddle index is the in-group position scaled by 2**stage.
    always_comb begin
        span    = LOG2N'(HALF) >> stage_q;
        mask    = span - LOG2N'(1);
        kx      = {1'b0, k};
        addr_a  = ((kx & ~mask) << 1) | (kx & mask);
        addr_b  = addr_a | span;
        tw_full = (kx & mask) << stage_q;

        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_addr   = '0;
        if (rd_en) begin
            rd_addr_a = addr_a;
            rd_addr_b = addr_b;
            tw_addr   = tw_full[KW-1:0];
        end
    end

    // Delay pipeline aligning butterfly enable and write-back with the read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            bf_enable <= 1'b0;
            wr_en     <= 1'b0;
            addr_a_d1 <= '0;
            addr_b_d1 <= '0;
            wr_addr_a <= '0;
            wr_addr_b <= '0;
        end else begin
            bf_enable <= rd_en;
            wr_en     <= bf_enable;
            addr_a_d1 <= rd_addr_a;
            addr_b_d1 <= rd_addr_b;
            wr_addr_a <= addr_a_d1;
            wr_addr_b <= addr_b_d1;
        end
    end

endmodule

// File: tb/tb_fft_bf_sequencer.sv
// Self-checking bench for fft_bf_sequencer at LOG2N=3 and LOG2N=10.
// Expected outputs come from a cycle-indexed model built from the stage/butterfly
// arithmetic (span, group, position) relative to the cycle a start was accepted.
module tb_fft_bf_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst3, start3, rst10, start10;
    logic       busy3, done3, rd3, bf3, wr3;
    logic [2:0] ra3, rb3, wa3, wb3;
    logic [1:0] tw3;
    logic [3:0] st3;
    logic       busy10, done10, rd10, bf10, wr10;
    logic [9:0] ra10, rb10, wa10, wb10;
    logic [8:0] tw10;
    logic [3:0] st10;

    fft_bf_sequencer #(.LOG2N(3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .busy(busy3), .done(done3),
        .rd_en(rd3), .rd_addr_a(ra3), .rd_addr_b(rb3), .tw_addr(tw3),
        .bf_enable(bf3), .wr_en(wr3), .wr_addr_a(wa3), .wr_addr_b(wb3), .stage(st3)
    );

    fft_bf_sequencer #(.LOG2N(10)) dut10 (
        .clk(clk), .rst(rst10), .start(start10), .busy(busy10), .done(done10),
        .rd_en(rd10), .rd_addr_a(ra10), .rd_addr_b(rb10), .tw_addr(tw10),
        .bf_enable(bf10), .wr_en(wr10), .wr_addr_a(wa10), .wr_addr_b(wb10), .stage(st10)
    );

    int vectors    = 0;
    int miscompares = 0;
    int n          = 0;
    bit act[2]     = '{0, 0};
    int t0[2]      = '{0, 0};
    int lg[2]      = '{3, 10};
    int wr3_cnt    = 0;
    int wr10_cnt   = 0;
    int hist[10][1024];
    string names[11] = '{"busy", "done", "rd_en", "rd_addr_a", "rd_addr_b", "tw_addr",
                         "bf_enable", "wr_en", "wr_addr_a", "wr_addr_b", "stage"};

    // Read issued at relative cycle r (r=1 is the first RUN cycle).
    function automatic void read_at(input int L, input int r, output int rd,
                                    output int a, output int b, output int tw);
        int h, p, s, j, span, pos, grp;
        h = 1 << (L - 1);
        p = h + 2;
        rd = 0; a = 0; b = 0; tw = 0;
        if (r < 1 || r > L * p) return;
        s = (r - 1) / p;
        j = (r - 1) % p;
        if (j >= h) return;
        span = (1 << L) >> (s + 1);
        pos  = j % span;
        grp  = j / span;
        rd   = 1;
        a    = grp * 2 * span + pos;
        b    = a + span;
        tw   = (pos << s) % (1 << (L - 1));
    endfunction

    function automatic void model(input int L, input bit ac, input int r,
                                  output int e[11], output bit chk[11]);
        int p, dcyc, rd, a, b, tw;
        p = (1 << (L - 1)) + 2;
        dcyc = L * p + 1;
        for (int f = 0; f < 11; f++) begin
            e[f] = 0;
            chk[f] = 1'b1;
        end
        if (!ac) return;
        e[0] = 1;
        e[1] = (r == dcyc) ? 1 : 0;
        read_at(L, r, rd, a, b, tw);
        e[2] = rd; e[3] = a; e[4] = b; e[5] = tw;
        read_at(L, r - 1, rd, a, b, tw);
        e[6] = rd;
        read_at(L, r - 2, rd, a, b, tw);
        e[7] = rd; e[8] = a; e[9] = b;
        if (r < dcyc) e[10] = (r - 1) / p;
        else chk[10] = 1'b0;
    endfunction

    task automatic check_dut(input int d, input logic [31:0] obs[11]);
        int e[11];
        bit chk[11];
        model(lg[d], act[d], n - t0[d], e, chk);
        for (int f = 0; f < 11; f++) begin
            if (chk[f]) begin
                vectors++;
                assert (obs[f] === 32'(e[f])) else begin
                    miscompares++;
                    $error("FAIL L%0d %s cycle %0d: observed %0d expected %0d",
                           lg[d], names[f], n, obs[f], e[f]);
                end
            end
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance the model.
    task automatic step(input logic s3, input logic r3, input logic s10, input logic r10);
        logic [31:0] o3[11];
        logic [31:0] o10[11];
        int r, p, dcyc;
        logic rr, ss;
        start3 = s3; rst3 = r3; start10 = s10; rst10 = r10;
        @(negedge clk);
        o3  = '{32'(busy3), 32'(done3), 32'(rd3), 32'(ra3), 32'(rb3), 32'(tw3),
                32'(bf3), 32'(wr3), 32'(wa3), 32'(wb3), 32'(st3)};
        o10 = '{32'(busy10), 32'(done10), 32'(rd10), 32'(ra10), 32'(rb10), 32'(tw10),
                32'(bf10), 32'(wr10), 32'(wa10), 32'(wb10), 32'(st10)};
        check_dut(0, o3);
        check_dut(1, o10);
        if (wr3 === 1'b1) wr3_cnt++;
        if (wr10 === 1'b1) begin
            if (wr10_cnt / 512 < 10) begin
                hist[wr10_cnt / 512][wa10]++;
                hist[wr10_cnt / 512][wb10]++;
            end
            wr10_cnt++;
        end
        for (int d = 0; d < 2; d++) begin
            r    = n - t0[d];
            p    = (1 << (lg[d] - 1)) + 2;
            dcyc = lg[d] * p + 1;
            rr   = (d == 0) ? r3 : r10;
            ss   = (d == 0) ? s3 : s10;
            if (rr) act[d] = 1'b0;
            else if (ss && !act[d]) begin
                act[d] = 1'b1;
                t0[d]  = n;
            end else if (act[d] && r == dcyc) act[d] = 1'b0;
        end
        @(posedge clk);
        #1;
        n++;
    endtask

    initial begin
        int bad;
        rst3 = 1'b1; rst10 = 1'b1; start3 = 1'b0; start10 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state, including start presented together with rst.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Full transform with ignored starts (fixed at 5 and 12, plus random).
        wr3_cnt = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int r = 1; r <= 19; r++)
            step((r == 5) || (r == 12) || ($urandom_range(0, 2) == 0), 1'b0, 1'b0, 1'b0);
        vectors++;
        assert (wr3_cnt === 12) else begin
            miscompares++;
            $error("FAIL wr_count_L3: observed %0d expected 12", wr3_cnt);
        end

        // Back-to-back start in the cycle after done.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int r = 1; r <= 19; r++)
            step($urandom_range(0, 3) == 0, 1'b0, 1'b0, 1'b0);
        repeat ($urandom_range(1, 4)) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Abort by reset at relative cycle 9, restart at 12.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int r = 1; r <= 8; r++) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int r = 1; r <= 19; r++)
            step($urandom_range(0, 3) == 0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Large transform.
        wr10_cnt = 0;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int r = 1; r <= 5141; r++)
            step(1'b0, 1'b0, $urandom_range(0, 7) == 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        assert (wr10_cnt === 5120) else begin
            miscompares++;
            $error("FAIL wr_count_L10: observed %0d expected 5120", wr10_cnt);
        end
        for (int s = 0; s < 10; s++) begin
            bad = 0;
            for (int a = 0; a < 1024; a++)
                if (hist[s][a] != 1) bad++;
            vectors++;
            assert (bad === 0) else begin
                miscompares++;
                $error("FAIL addr_once_stage%0d: observed %0d bad addresses expected 0", s, bad);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fft_bf_sequencer.md
Name: fft_bf_sequencer

Overview:
- Drives the radix-2 DIF butterfly over an in-place N-point data RAM and a twiddle ROM.
- Per stage and butterfly, it:
  - issues read addresses for the operand pair and twiddle;
  - asserts the butterfly enable aligned with the returned data;
  - issues write-back to the same addresses.
- Sits between the FFT top-level start/done control and the memory/butterfly datapath. Output ordering is bit-reversed and is handled downstream.

Parameters:
- LOG2N, 10, log2 of FFT size N (N = 2**LOG2N, minimum 2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run a full transform; honoured only in IDLE.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the transform is complete.
- rd_en  out  1  data RAM / twiddle ROM read strobe.
- rd_addr_a  out  LOG2N  address of operand a.
- rd_addr_b  out  LOG2N  address of operand b.
- tw_addr  out  LOG2N-1  twiddle ROM index.
- bf_enable  out  1  butterfly enable; equals rd_en delayed 1 cycle.
- wr_en  out  1  data RAM write strobe; equals rd_en delayed 2 cycles.
- wr_addr_a  out  LOG2N  write address for Xa; rd_addr_a delayed 2 cycles.
- wr_addr_b  out  LOG2N  write address for Xb; rd_addr_b delayed 2 cycles.
- stage  out  4  current stage index, 0..LOG2N-1.

Behaviour:
- Reset values:
  - All outputs 0 and state IDLE.
  - Stage counter, butterfly counter, drain counter and delay pipeline all cleared.
  - Reset mid-transform aborts immediately: no wr_en in the cycle after rst is seen high, and no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 -> RUN with stage=0, k=0.
  - RUN: one butterfly issued per cycle (rd_en=1). When k = N/2-1 -> DRAIN, k cleared.
  - DRAIN: rd_en=0 for exactly 2 cycles, letting the last write land before any read of the next stage. Then -> RUN with stage+1, or -> DONE if stage = LOG2N-1.
  - DONE: done=1 for one cycle, then -> IDLE.
- start while busy is ignored. start in the same cycle as rst is ignored.
- Address generation for stage s, butterfly k:
  - span = N >> (s+1)
  - pos = k mod span
  - group = k / span
  - a = group*2*span + pos
  - b = a + span
  - tw_addr = pos << s, truncated to LOG2N-1 bits
  - All arithmetic is unsigned with no wrap; b <= N-1 always holds.
- Pipeline timing, assuming 1-cycle synchronous RAM and ROM reads and the 1-cycle registered butterfly:
  - read issued at cycle c;
  - bf_enable at c+1;
  - wr_en and wr_addr_* at c+2.
  - Delay registers also shift during DRAIN, so the final writes of every stage are emitted.
- Total latency for a start accepted at cycle 0:
  - RUN starts at cycle 1.
  - Each stage takes N/2 + 2 cycles.
  - done is high at cycle LOG2N*(N/2+2)+1.
  - busy is high from cycle 1 through the done cycle inclusive.
- wr_en count per transform is exactly LOG2N*N/2, and no address is written twice within a stage.

Test Plan:
- LOG2N=3, reset then start at cycle 0 -> stage 0 issues (a,b,tw) = (0,4,0), (1,5,1), (2,6,2), (3,7,3) on cycles 1..4. bf_enable on cycles 2..5; wr_en on cycles 3..6 with matching addresses.
- LOG2N=3, stage 1 -> (0,2,0), (1,3,2), (4,6,0), (5,7,2) on cycles 7..10. Stage 2 -> (0,1,0), (2,3,0), (4,5,0), (6,7,0) on cycles 13..16. done=1 only at cycle 19, then busy=0 at cycle 20.
- Start pulsed at cycles 5 and 12 during a transform -> no effect on sequence or timing. Exactly 12 wr_en pulses occur.
- rst asserted at cycle 9 -> at cycle 10 all outputs 0 and state IDLE. No done pulse. A new start at cycle 12 reproduces the first-scenario sequence shifted by 12 cycles.
- LOG2N=10, start -> done at cycle 10*514+1 = 5141. 5120 wr_en pulses. Every stage writes each of addresses 0..1023 exactly once.
- Back-to-back: start asserted in the cycle after done -> accepted, with RUN in the following cycle and identical timing.
